// File: rtl/neuron_update_scheduler.sv
// neuron_update_scheduler: per-timestep sweep sequencer for the shared FP32 neuron datapath.
// For every neuron index it reads the membrane potential, issues it to the datapath, writes
// the returned potential back and emits a spike event if the neuron fired.
// Optional feature: define SPIKE_COUNT_EN to add the spike_count output and its counter.
module neuron_update_scheduler #(
    parameter int unsigned NUM_NEURONS = 32,
    parameter int unsigned ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       cfg_v_thresh,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd_data,
    output logic [31:0]       mem_wr_data,
    output logic              dp_valid,
    input  logic              dp_ready,
    output logic [31:0]       dp_potential,
    output logic [31:0]       dp_v_thresh,
    input  logic              dp_done,
    input  logic [31:0]       dp_result,
    input  logic              dp_spiked,
    output logic              spike_valid,
    output logic [ADDR_W-1:0] spike_id,
    input  logic              spike_ready
`ifdef SPIKE_COUNT_EN
    ,
    output logic [ADDR_W:0]   spike_count
`endif
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_NEURONS - 1);

    typedef enum logic [3:0] {
        StIdle, StRd, StRdw, StIss, StWdp, StWr, StEmit, StNxt, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       thresh_q, thresh_d;
    logic [31:0]       pot_q, pot_d;
    logic [31:0]       result_q, result_d;
    logic              spiked_q, spiked_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic              dp_valid_q, dp_valid_d;
    logic              spike_valid_q, spike_valid_d;
`ifdef SPIKE_COUNT_EN
    logic [ADDR_W:0]   cnt_q, cnt_d;
`endif

    // Next-state and datapath-register updates of the sweep FSM.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        thresh_d = thresh_q;
        pot_d    = pot_q;
        result_d = result_q;
        spiked_d = spiked_q;
`ifdef SPIKE_COUNT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StRd;
                    idx_d    = '0;
                    thresh_d = cfg_v_thresh;
`ifdef SPIKE_COUNT_EN
                    cnt_d    = '0;
`endif
                end
            end
            StRd:  state_d = StRdw;
            StRdw: begin
                pot_d   = mem_rd_data;
                state_d = StIss;
            end
            StIss: begin
                if (dp_ready) state_d = StWdp;
            end
            // dp_done is only honoured here, so stray pulses elsewhere are dropped.
            StWdp: begin
                if (dp_done) begin
                    result_d = dp_result;
                    spiked_d = dp_spiked;
                    state_d  = StWr;
                end
            end
            StWr: state_d = spiked_q ? StEmit : StNxt;
            StEmit: begin
                if (spike_ready) begin
                    state_d = StNxt;
`ifdef SPIKE_COUNT_EN
                    cnt_d   = cnt_q + (ADDR_W + 1)'(1);
`endif
                end
            end
            StNxt: begin
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = StRd;
                end
            end
            StDone: begin
                idx_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes are decoded from the next state so they come straight out of flops.
    always_comb begin
        busy_d        = (state_d != StIdle) && (state_d != StDone);
        done_d        = (state_d == StDone);
        rd_en_d       = (state_d == StRd);
        wr_en_d       = (state_d == StWr);
        dp_valid_d    = (state_d == StIss);
        spike_valid_d = (state_d == StEmit);
    end

    // State and registered outputs; reset aborts any sweep without a further write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            thresh_q      <= '0;
            pot_q         <= '0;
            result_q      <= '0;
            spiked_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rd_en_q       <= 1'b0;
            wr_en_q       <= 1'b0;
            dp_valid_q    <= 1'b0;
            spike_valid_q <= 1'b0;
`ifdef SPIKE_COUNT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            thresh_q      <= thresh_d;
            pot_q         <= pot_d;
            result_q      <= result_d;
            spiked_q      <= spiked_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            rd_en_q       <= rd_en_d;
            wr_en_q       <= wr_en_d;
            dp_valid_q    <= dp_valid_d;
            spike_valid_q <= spike_valid_d;
`ifdef SPIKE_COUNT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign mem_rd_en    = rd_en_q;
    assign mem_wr_en    = wr_en_q;
    assign mem_addr     = idx_q;
    assign mem_wr_data  = result_q;
    assign dp_valid     = dp_valid_q;
    assign dp_potential = pot_q;
    assign dp_v_thresh  = thresh_q;
    assign spike_valid  = spike_valid_q;
    assign spike_id     = idx_q;
`ifdef SPIKE_COUNT_EN
    assign spike_count  = cnt_q;
`endif

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// tb_neuron_update_scheduler: drives the scheduler against a RAM / datapath / spike-sink
// environment and compares every sweep with the expected per-neuron outcome.
module tb_neuron_update_scheduler;

    localparam int N  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   cfg_v_thresh = '0;
    logic          busy, done, mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rd_data = '0;
    logic [31:0]   mem_wr_data;
    logic          dp_valid;
    logic          dp_ready = 1'b0;
    logic [31:0]   dp_potential, dp_v_thresh;
    logic          dp_done = 1'b0;
    logic [31:0]   dp_result = '0;
    logic          dp_spiked = 1'b0;
    logic          spike_valid;
    logic [AW-1:0] spike_id;
    logic          spike_ready = 1'b0;
`ifdef SPIKE_COUNT_EN
    logic [AW:0]   spike_count;
`endif

    neuron_update_scheduler #(.NUM_NEURONS(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_v_thresh(cfg_v_thresh),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_data(mem_wr_data),
        .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_potential(dp_potential),
        .dp_v_thresh(dp_v_thresh), .dp_done(dp_done), .dp_result(dp_result),
        .dp_spiked(dp_spiked), .spike_valid(spike_valid), .spike_id(spike_id),
`ifdef SPIKE_COUNT_EN
        .spike_count(spike_count),
`endif
        .spike_ready(spike_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference tables: RAM contents, per-neuron datapath answers, expected threshold.
    logic [31:0] ram [N];
    logic [31:0] pot_exp [N];
    logic [31:0] res [N];
    bit          spk [N];
    logic [31:0] thr_exp;

    // Environment knobs and observation logs.
    int  rdy_delay = 0, lat = 1, stall = 0;
    bit  spur_en = 0;
    int  wr_addr_q[$], rd_addr_q[$], spike_q[$];
    logic [31:0] wr_data_q[$];
    int  hs_cnt = 0, done_cnt = 0, busy_cnt = 0, done_cyc = 0, start_cyc = 0;

    function automatic logic [127:0] outs();
        return {22'd0, busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, dp_valid,
                dp_potential, dp_v_thresh, spike_valid, spike_id};
    endfunction

    // Environment: RAM with 1-cycle read latency, datapath, spike sink; acts on falling edges.
    initial begin : env
        int vcnt, scnt, cd, cur, rd_addr, prev_sid;
        bit rd_pend, wait_dp, wait_sp;
        logic [31:0] prev_pot;
        vcnt = 0; scnt = 0; cd = 0; cur = 0; rd_addr = 0; prev_sid = 0;
        rd_pend = 0; wait_dp = 0; wait_sp = 0; prev_pot = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                vcnt = 0; scnt = 0; cd = 0; rd_pend = 0; wait_dp = 0; wait_sp = 0;
                dp_ready = 0; dp_done = 0; dp_spiked = 0; spike_ready = 0;
                continue;
            end
            if (mem_wr_en) begin
                ram[mem_addr] = mem_wr_data;
                wr_addr_q.push_back(int'(mem_addr));
                wr_data_q.push_back(mem_wr_data);
            end
            mem_rd_data = rd_pend ? ram[rd_addr] : $urandom();
            rd_pend = mem_rd_en;
            rd_addr = int'(mem_addr);
            if (mem_rd_en) rd_addr_q.push_back(int'(mem_addr));

            dp_done = 0; dp_spiked = 0; dp_result = $urandom();
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    dp_done = 1; dp_result = res[cur]; dp_spiked = spk[cur];
                end
            end else if (spur_en && mem_rd_en) begin
                dp_done = 1; dp_spiked = 1;
            end
            if (wait_dp) begin
                chk("dp_valid_held", dp_valid, 1);
                chk("dp_potential_held", dp_potential, prev_pot);
            end
            if (dp_valid) begin
                dp_ready = (vcnt >= rdy_delay);
                vcnt++;
                if (dp_ready) begin
                    chk("dp_req_in_range", hs_cnt < N, 1);
                    if (hs_cnt < N) chk("dp_potential", dp_potential, pot_exp[hs_cnt]);
                    chk("dp_v_thresh", dp_v_thresh, thr_exp);
                    cur = hs_cnt % N; hs_cnt++; cd = lat; vcnt = 0;
                end
                wait_dp = !dp_ready;
                prev_pot = dp_potential;
            end else begin
                vcnt = 0; dp_ready = (rdy_delay == 0); wait_dp = 0;
            end

            if (wait_sp) begin
                chk("spike_valid_held", spike_valid, 1);
                chk("spike_id_held", spike_id, prev_sid);
                chk("no_write_during_emit", mem_wr_en, 0);
            end
            if (spike_valid) begin
                spike_ready = (scnt >= stall);
                scnt++;
                if (spike_ready) begin
                    spike_q.push_back(int'(spike_id));
                    scnt = 0;
                end
                wait_sp = !spike_ready;
                prev_sid = int'(spike_id);
            end else begin
                spike_ready = 0; scnt = 0; wait_sp = 0;
            end

            if (done) begin
                done_cnt++; done_cyc = cyc;
                chk("busy_low_at_done", busy, 0);
            end
            if (busy) busy_cnt++;
        end
    end

    task automatic arm(input logic [31:0] thr, input int rd, input int lt, input int st,
                       input bit sp);
        rdy_delay = rd; lat = lt; stall = st; spur_en = sp;
        for (int i = 0; i < N; i++) pot_exp[i] = ram[i];
        thr_exp = thr;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); spike_q.delete();
        hs_cnt = 0; done_cnt = 0; busy_cnt = 0;
        @(negedge clk); #1;
        start = 1; cfg_v_thresh = thr; start_cyc = cyc + 1;
        @(negedge clk); #1;
        start = 0; cfg_v_thresh = $urandom();
    endtask

    task automatic run_sweep(input logic [31:0] thr, input int rd, input int lt, input int st,
                             input bit sp, input bit restart, input string tag);
        int t;
        int exp_sp[$];
        arm(thr, rd, lt, st, sp);
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            @(negedge clk); #1;
            t++;
            start = restart && (t == 10);
            if (restart && t == 10) cfg_v_thresh = $urandom();
        end
        chk({tag, "_done_within_bound"}, done_cnt > 0, 1);
        // Sitting in the DONE cycle now: this start must be dropped.
        start = 1;
        @(negedge clk); #1;
        start = 0;
        repeat (4) @(negedge clk);
        #1;
        chk({tag, "_idle_after_done"}, busy, 0);
        chk({tag, "_single_done"}, done_cnt, 1);
        chk({tag, "_requests"}, hs_cnt, N);
        chk({tag, "_write_count"}, wr_addr_q.size(), N);
        for (int i = 0; i < N && i < wr_addr_q.size(); i++) begin
            chk({tag, "_write_addr"}, wr_addr_q[i], i);
            chk({tag, "_write_data"}, wr_data_q[i], res[i]);
        end
        for (int i = 0; i < N; i++) chk({tag, "_ram"}, ram[i], res[i]);
        chk({tag, "_read_count"}, rd_addr_q.size(), N);
        for (int i = 0; i < N && i < rd_addr_q.size(); i++)
            chk({tag, "_read_addr"}, rd_addr_q[i], i);
        for (int i = 0; i < N; i++) if (spk[i]) exp_sp.push_back(i);
        chk({tag, "_spike_count"}, spike_q.size(), exp_sp.size());
        for (int i = 0; i < exp_sp.size() && i < spike_q.size(); i++)
            chk({tag, "_spike_id"}, spike_q[i], exp_sp[i]);
    endtask

    task automatic randomize_tables(input bit with_spikes);
        for (int i = 0; i < N; i++) begin
            ram[i] = $urandom();
            res[i] = $urandom();
            spk[i] = with_spikes ? bit'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    initial begin : main
        int t;
        for (int i = 0; i < N; i++) begin ram[i] = '0; res[i] = '0; spk[i] = 0; end
        thr_exp = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", outs(), '0);
        #1 rst_n = 1;

        // T1: zero RAM, result 0.5, no spikes, ready tied high, latency 1.
        for (int i = 0; i < N; i++) begin ram[i] = '0; res[i] = 32'h3F00_0000; spk[i] = 0; end
        run_sweep(32'h3F80_0000, 0, 1, 0, 0, 0, "t1");
        chk("t1_done_latency", done_cyc - start_cyc, 24);
        chk("t1_busy_cycles", busy_cnt, 24);

        // T2: neuron 2 fires with result 0.2.
        randomize_tables(0);
        res[2] = 32'h3E4C_CCCD; spk[2] = 1;
        run_sweep($urandom(), 0, 1, 0, 0, 0, "t2");
`ifdef SPIKE_COUNT_EN
        chk("t2_spike_count_out", spike_count, 1);
`endif

        // T3: downstream stalls each spike for 5 cycles.
        randomize_tables(0);
        spk[1] = 1; spk[3] = 1;
        run_sweep($urandom(), 0, 1, 5, 0, 0, "t3");

        // T4: slow handshake, long latency, stray dp_done pulses during reads.
        randomize_tables(1);
        run_sweep($urandom(), 3, 7, 1, 1, 0, "t4");

        // T5: reset while waiting on the datapath for neuron 1.
        randomize_tables(0);
        arm($urandom(), 0, 10, 0, 0);
        t = 0;
        while (hs_cnt < 2 && t < 500) begin @(negedge clk); #1; t++; end
        chk("t5_reached_idx1", hs_cnt, 2);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("t5_outputs_cleared", outs(), '0);
        chk("t5_writes_before_reset", wr_addr_q.size(), 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        repeat (3) @(negedge clk);
        chk("t5_no_write_after_reset", wr_addr_q.size(), 1);
        randomize_tables(1);
        run_sweep($urandom(), 1, 2, 0, 0, 0, "t5b");

        // T6: start re-pulsed mid-sweep along with a new threshold.
        randomize_tables(1);
        run_sweep($urandom(), 0, 2, 1, 0, 1, "t6");

        // Random mixes of handshake timing.
        for (int k = 0; k < 3; k++) begin
            randomize_tables(1);
            run_sweep($urandom(), $urandom_range(0, 2), $urandom_range(1, 4),
                      $urandom_range(0, 3), bit'($urandom_range(0, 1)), 0, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
